barrel_shifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 32-bit combinational barrel shifter.
- Adds rotate modes, a zero flag, and a valid/ready handshake.
- The log2(WIDTH) shift layers are each registered, so the block closes timing at ALU clock rates.
- Sits between the ALU operand mux and the writeback mux; multi-cycle shift ops go through it.

---
 rtl/barrel_shifter_pipe.sv | 114 +++++++++++
 tb/tb_barrel_shifter_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SRA/SRL/SLL/ROR/ROL over log2(WIDTH) registered layers
// with a valid/ready handshake and a registered zero flag.
module barrel_shifter_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [2:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero
);

    logic             advance;

    logic [SHW-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [SHW-1:0]   b_q     [SHW];
    logic [SHW-1:0]   b_d     [SHW];
    logic [2:0]       aluc_q  [SHW];
    logic [2:0]       aluc_d  [SHW];
    logic [SHW-1:0]   sign_q, sign_d;
    logic             zero_q, zero_d;

    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_b    [SHW];
    logic [2:0]       src_aluc [SHW];
    logic [SHW-1:0]   src_sign;

    // One layer of the shifter; SRA fills from the sign captured at input, not the current MSB.
    function automatic logic [WIDTH-1:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic             sgn,
        input logic [2:0]       op,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        fill = sgn ? ~({WIDTH{1'b1}} >> sh) : '0;
        case (op)
            3'b000:  return (d >> sh) | fill;
            3'b001:  return d >> sh;
            3'b100:  return (d >> sh) | (d << (WIDTH - sh));
            3'b101:  return (d << sh) | (d >> (WIDTH - sh));
            default: return d << sh;
        endcase
    endfunction

    assign advance   = !(valid_q[SHW-1] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = valid_q[SHW-1];
    assign c         = data_q[SHW-1];
    assign zero      = zero_q;

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = a;
        src_b[0]     = b;
        src_aluc[0]  = aluc;
        src_sign[0]  = a[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_b[k]     = b_q[k-1];
            src_aluc[k]  = aluc_q[k-1];
            src_sign[k]  = sign_q[k-1];
        end
    end

    // Stage k applies a shift by 2^k when bit k of the carried shift amount is set.
    always_comb begin
        valid_d = '0;
        sign_d  = '0;
        for (int k = 0; k < SHW; k++) begin
            valid_d[k] = src_valid[k];
            sign_d[k]  = src_sign[k];
            b_d[k]     = src_b[k];
            aluc_d[k]  = src_aluc[k];
            data_d[k]  = src_b[k][k] ? stage_op(src_data[k], src_sign[k], src_aluc[k], 1 << k)
                                     : src_data[k];
        end
        zero_d = (data_d[SHW-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            sign_q  <= '0;
            zero_q  <= 1'b1;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                b_q[k]    <= '0;
                aluc_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
                b_q[k]    <= b_d[k];
                aluc_q[k] <= aluc_d[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=32): directed cases, streaming,
// stalls, mid-flight reset and a long random run against a plain-arithmetic model.
module tb_barrel_shifter_pipe;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [2:0]       aluc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic             z;
        int               acc;
        bit               lat;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [SHW-1:0]   b;
        logic [2:0]       op;
        logic [WIDTH-1:0] exp;
    } dir_t;

    exp_t q[$];
    dir_t dirs[12];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle_cnt = 0;
    bit   rand_mode = 0;
    bit   hold      = 0;

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: whole-word shifts and rotates via a doubled word.
    function automatic logic [WIDTH-1:0] refModel(input logic [WIDTH-1:0] av,
                                                   input logic [SHW-1:0] bv,
                                                   input logic [2:0] op);
        logic signed [WIDTH-1:0] s;
        logic [2*WIDTH-1:0]      dbl;
        s   = av;
        dbl = {av, av};
        case (op)
            3'b000:  begin s = s >>> bv; return s; end
            3'b001:  return av >> bv;
            3'b100:  begin dbl = dbl >> bv; return dbl[WIDTH-1:0]; end
            3'b101:  begin dbl = dbl << bv; return dbl[2*WIDTH-1:WIDTH]; end
            default: return av << bv;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cycle_cnt);
        end
    endtask

    // Entered and left at a falling edge; in_valid drops on return unless the next call re-raises it.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [SHW-1:0] bv,
                                 input logic [2:0] op, input bit lat, input bit use_exp,
                                 input logic [WIDTH-1:0] exp_c);
        exp_t e;
        bit   done;
        int   tries;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        aluc     = op;
        done     = 0;
        tries    = 0;
        while (!done) begin
            #4;
            if (in_ready) begin
                e.c   = use_exp ? exp_c : refModel(av, bv, op);
                e.z   = (e.c == '0);
                e.acc = cycle_cnt;
                e.lat = lat;
                q.push_back(e);
                done  = 1;
            end
            @(negedge clk);
            if (!done) begin
                tries++;
                if (tries > 1000) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!hold) out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_output", c, 32'hx);
                end else begin
                    e = q.pop_front();
                    checkOutput("c", c, e.c);
                    checkOutput("zero", {31'd0, zero}, {31'd0, e.z});
                    if (e.lat) checkOutput("latency", cycle_cnt - e.acc, SHW);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] av;
        int               w;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        aluc      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_c", c, 32'd0);
        checkOutput("reset_zero", {31'd0, zero}, 32'd1);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        dirs[0]  = '{32'h8000_0000, 5'd4,  3'b000, 32'hF800_0000};
        dirs[1]  = '{32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001};
        dirs[2]  = '{32'h0000_0001, 5'd31, 3'b010, 32'h8000_0000};
        dirs[3]  = '{32'h0000_0001, 5'd31, 3'b011, 32'h8000_0000};
        dirs[4]  = '{32'h0000_0001, 5'd31, 3'b111, 32'h8000_0000};
        dirs[5]  = '{32'h0000_0001, 5'd1,  3'b100, 32'h8000_0000};
        dirs[6]  = '{32'h8000_0001, 5'd4,  3'b101, 32'h0000_0018};
        dirs[7]  = '{32'hDEAD_BEEF, 5'd0,  3'b101, 32'hDEAD_BEEF};
        dirs[8]  = '{32'h0001_0000, 5'd16, 3'b010, 32'h0000_0000};
        dirs[9]  = '{32'h8000_0000, 5'd31, 3'b000, 32'hFFFF_FFFF};
        dirs[10] = '{32'h8000_0001, 5'd0,  3'b000, 32'h8000_0001};
        dirs[11] = '{32'h1234_5678, 5'd0,  3'b100, 32'h1234_5678};
        for (int i = 0; i < 12; i++)
            applyStimulus(dirs[i].a, dirs[i].b, dirs[i].op, 1, 1, dirs[i].exp);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 8; i++)
            applyStimulus($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1, 0, '0);
        repeat (8) @(negedge clk);

        // Stall the output for three cycles while input is still streaming.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0, 0, '0);
            end
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    #4;
                    w++;
                end while (!out_valid && w < 100);
                @(negedge clk);
                hold      = 1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #4;
                    checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    checkOutput("stall_c", c, (q.size() > 0) ? q[0].c : 32'hx);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                hold      = 0;
            end
        join
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3; i++)
            applyStimulus($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0, 0, '0);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h0000_1234;
        b        = '0;
        aluc     = '0;
        q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #4;
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_c", c, 32'd0);
        checkOutput("flush_zero", {31'd0, zero}, 32'd1);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        applyStimulus(32'h0000_00F0, 5'd4, 3'b001, 1, 1, 32'h0000_000F);
        repeat (8) @(negedge clk);

        rand_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 3))
                0:       av = 32'h8000_0000 | $urandom;
                1:       av = 32'h0000_0001 << $urandom_range(0, 31);
                default: av = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            applyStimulus(av, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0, 0, '0);
        end
        rand_mode = 0;

        w = 0;
        while (q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) checkOutput("drain_timeout", q.size(), 32'd0);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
